// File: rtl/bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bank_scheduler
// Description : Ping-pong frame bank scheduler. Two frame banks alternate
//               between an input engine (fills a frame) and an output mapper
//               (drains it). Frames drain in fill order. Each bank keeps the
//               minimum nonzero CDF of its frame; on an output grant the
//               bank's cdf_min and divisor (PIXELS - cdf_min) are presented.
// Ports       : clock, reset_n      - clock, async active-low reset
//               start               - level enable for new grants
//               in_req/in_grant/in_bank/in_done   - input engine handshake
//               cdf_valid/cdf_min   - cdf_min capture for the filling bank
//               out_req/out_grant/out_bank/out_done - output mapper handshake
//               cdf_min_out/divisor - parameters of the bank being drained
//               bank_full           - bit i set while bank i is FULL
//               frame_count         - drained frames (wraps)
//               err                 - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module bank_scheduler #(
    parameter int PIXELS = 307200,
    parameter int CW     = 20
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_req,
    output logic          in_grant,
    output logic          in_bank,
    input  logic          in_done,
    input  logic          cdf_valid,
    input  logic [CW-1:0] cdf_min,
    input  logic          out_req,
    output logic          out_grant,
    output logic          out_bank,
    input  logic          out_done,
    output logic [CW-1:0] cdf_min_out,
    output logic [CW-1:0] divisor,
    output logic [1:0]    bank_full,
    output logic [15:0]   frame_count,
    output logic          err
);

    localparam logic [1:0]    c_st_empty    = 2'd0;
    localparam logic [1:0]    c_st_filling  = 2'd1;
    localparam logic [1:0]    c_st_full     = 2'd2;
    localparam logic [1:0]    c_st_draining = 2'd3;
    localparam logic [CW-1:0] c_pixels      = CW'(PIXELS);

    logic [1:0]    r_state [0:1];
    logic [CW-1:0] r_cdf   [0:1];
    logic          r_fill_ptr;
    logic          r_drain_ptr;
    logic          r_cdf_seen;
    logic          r_in_grant;
    logic          r_in_bank;
    logic          r_out_grant;
    logic          r_out_bank;
    logic [CW-1:0] r_cdf_min_out;
    logic [CW-1:0] r_divisor;
    logic [1:0]    r_bank_full;
    logic [15:0]   r_frame_count;
    logic          r_err;

    logic          w_in_issue;
    logic          w_out_issue;
    logic          w_in_finish;
    logic          w_out_finish;
    logic [CW-1:0] w_cdf_sel;
    logic          w_cdf_over;
    logic [CW-1:0] w_div;
    logic          w_proto_err;
    logic [1:0]    w_state_nxt [0:1];
    logic [1:0]    w_bank_full;

    // Grant decisions look only at registered bank state, so a bank released
    // by out_done this cycle is not visible as EMPTY until the next cycle.
    assign w_in_issue   = start & in_req & ~r_in_grant
                        & (r_state[r_fill_ptr] == c_st_empty);
    assign w_out_issue  = start & out_req & ~r_out_grant
                        & (r_state[r_drain_ptr] == c_st_full);
    assign w_in_finish  = in_done & r_in_grant;
    assign w_out_finish = out_done & r_out_grant;

    assign w_cdf_sel  = r_cdf[r_drain_ptr];
    assign w_cdf_over = (w_cdf_sel > c_pixels);
    assign w_div      = w_cdf_over ? '0 : (c_pixels - w_cdf_sel);

    // A frame finishing with neither an earlier nor a coincident cdf_valid
    // counts as a missing cdf_min.
    assign w_proto_err = (in_done & ~r_in_grant)
                       | (out_done & ~r_out_grant)
                       | (cdf_valid & ~r_in_grant)
                       | (w_in_finish & ~cdf_valid & ~r_cdf_seen)
                       | (w_out_issue & w_cdf_over);

    // The four events always target distinct banks (a bank is in exactly one
    // state), so the per-bank updates never conflict.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_in_issue && (r_fill_ptr == i[0]))
                w_state_nxt[i] = c_st_filling;
            if (w_in_finish && (r_in_bank == i[0]))
                w_state_nxt[i] = c_st_full;
            if (w_out_issue && (r_drain_ptr == i[0]))
                w_state_nxt[i] = c_st_draining;
            if (w_out_finish && (r_out_bank == i[0]))
                w_state_nxt[i] = c_st_empty;
            w_bank_full[i] = (w_state_nxt[i] == c_st_full);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state[0]    <= c_st_empty;
            r_state[1]    <= c_st_empty;
            r_cdf[0]      <= '0;
            r_cdf[1]      <= '0;
            r_cdf_seen    <= 1'b0;
            r_fill_ptr    <= 1'b0;
            r_drain_ptr   <= 1'b0;
            r_in_grant    <= 1'b0;
            r_in_bank     <= 1'b0;
            r_out_grant   <= 1'b0;
            r_out_bank    <= 1'b0;
            r_cdf_min_out <= '0;
            r_divisor     <= '0;
            r_bank_full   <= 2'b00;
            r_frame_count <= 16'd0;
            r_err         <= 1'b0;
        end else begin
            r_state[0]  <= w_state_nxt[0];
            r_state[1]  <= w_state_nxt[1];
            // Registered from the next state so bank_full tracks the bank
            // state registers cycle for cycle.
            r_bank_full <= w_bank_full;
            r_err       <= r_err | w_proto_err;

            if (w_in_issue) begin
                r_in_grant <= 1'b1;
                r_in_bank  <= r_fill_ptr;
                r_fill_ptr <= ~r_fill_ptr;
                r_cdf_seen <= 1'b0;
            end else if (w_in_finish) begin
                r_in_grant <= 1'b0;
            end

            // Last cdf_valid wins, including one coincident with in_done.
            if (r_in_grant && cdf_valid) begin
                r_cdf[r_in_bank] <= cdf_min;
                r_cdf_seen       <= 1'b1;
            end else if (w_in_finish && !r_cdf_seen) begin
                r_cdf[r_in_bank] <= '0;
            end

            if (w_out_issue) begin
                r_out_grant   <= 1'b1;
                r_out_bank    <= r_drain_ptr;
                r_drain_ptr   <= ~r_drain_ptr;
                r_cdf_min_out <= w_cdf_sel;
                r_divisor     <= w_div;
            end else if (w_out_finish) begin
                r_out_grant   <= 1'b0;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign in_grant    = r_in_grant;
    assign in_bank     = r_in_bank;
    assign out_grant   = r_out_grant;
    assign out_bank    = r_out_bank;
    assign cdf_min_out = r_cdf_min_out;
    assign divisor     = r_divisor;
    assign bank_full   = r_bank_full;
    assign frame_count = r_frame_count;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bank_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bank_scheduler
// Description : Self-checking bench for bank_scheduler. Directed scenarios
//               plus a randomized frame sequence checked against a frame
//               queue model (fill order in, same order out).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_scheduler;

    localparam int PIXELS = 307200;
    localparam int CW     = 20;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          in_req = 1'b0;
    logic          in_done = 1'b0;
    logic          cdf_valid = 1'b0;
    logic [CW-1:0] cdf_min = '0;
    logic          out_req = 1'b0;
    logic          out_done = 1'b0;
    logic          in_grant, in_bank, out_grant, out_bank, err;
    logic [CW-1:0] cdf_min_out, divisor;
    logic [1:0]    bank_full;
    logic [15:0]   frame_count;

    bank_scheduler #(.PIXELS(PIXELS), .CW(CW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in_req(in_req), .in_grant(in_grant), .in_bank(in_bank),
        .in_done(in_done), .cdf_valid(cdf_valid), .cdf_min(cdf_min),
        .out_req(out_req), .out_grant(out_grant), .out_bank(out_bank),
        .out_done(out_done), .cdf_min_out(cdf_min_out), .divisor(divisor),
        .bank_full(bank_full), .frame_count(frame_count), .err(err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model: frames waiting to drain (their cdf_min), expected bank indices.
    int q_cdf[$];
    int exp_fill;
    int exp_drain;
    int exp_frames;

    function automatic int exp_div(input int c);
        return (c > PIXELS) ? 0 : PIXELS - c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        start = 0; in_req = 0; in_done = 0; cdf_valid = 0; cdf_min = '0;
        out_req = 0; out_done = 0;
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        tick();
        q_cdf.delete();
        exp_fill = 0; exp_drain = 0; exp_frames = 0;
    endtask

    task automatic fill_frame(input int cdf, input bit give, input bit coincide);
        int k;
        int n;
        in_req = 1;
        k = 0;
        while (!in_grant && k < 50) begin tick(); k++; end
        in_req = 0;
        tests++;
        if (in_grant !== 1'b1 || in_bank !== 1'(exp_fill)) begin
            fails++;
            $display("FAIL fill_grant: in_grant=%0b in_bank=%0b, required 1/%0d", in_grant, in_bank, exp_fill);
        end
        exp_fill ^= 1;
        if (give) begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                cdf_valid = 1; cdf_min = 20'($urandom);
                tick();
                cdf_valid = 0;
                repeat ($urandom_range(0, 2)) tick();
            end
            cdf_min = 20'(cdf); cdf_valid = 1;
            if (!coincide) begin
                tick();
                cdf_valid = 0;
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        in_done = 1;
        tick();
        in_done = 0; cdf_valid = 0;
        tests++;
        if (in_grant !== 1'b0) begin
            fails++;
            $display("FAIL fill_release: in_grant=%0b, required 0", in_grant);
        end
        q_cdf.push_back(give ? cdf : 0);
    endtask

    task automatic drain_frame(input bit hold_req);
        int k;
        int c;
        out_req = 1;
        k = 0;
        while (!out_grant && k < 50) begin tick(); k++; end
        if (!hold_req) out_req = 0;
        c = (q_cdf.size() > 0) ? q_cdf.pop_front() : 0;
        tests++;
        if (out_grant !== 1'b1 || out_bank !== 1'(exp_drain) ||
            cdf_min_out !== 20'(c) || divisor !== 20'(exp_div(c))) begin
            fails++;
            $display("FAIL drain_grant: grant=%0b bank=%0b cdf=%0d div=%0d, required 1/%0d/%0d/%0d",
                     out_grant, out_bank, cdf_min_out, divisor, exp_drain, c, exp_div(c));
        end
        exp_drain ^= 1;
        repeat ($urandom_range(0, 3)) tick();
        tests++;
        if (cdf_min_out !== 20'(c) || divisor !== 20'(exp_div(c))) begin
            fails++;
            $display("FAIL drain_hold: cdf=%0d div=%0d, required %0d/%0d", cdf_min_out, divisor, c, exp_div(c));
        end
        out_done = 1;
        tick();
        out_done = 0;
        exp_frames++;
        tests++;
        if (out_grant !== 1'b0 || frame_count !== 16'(exp_frames)) begin
            fails++;
            $display("FAIL drain_done: out_grant=%0b frame_count=%0d, required 0/%0d", out_grant, frame_count, exp_frames);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({in_grant, in_bank, out_grant, out_bank} !== 4'b0) begin
            fails++;
            $display("FAIL reset_grants: %b, required 0000", {in_grant, in_bank, out_grant, out_bank});
        end
        tests++;
        if (cdf_min_out !== '0 || divisor !== '0) begin
            fails++;
            $display("FAIL reset_data: cdf=%0d div=%0d, required 0/0", cdf_min_out, divisor);
        end
        tests++;
        if (bank_full !== 2'b0 || frame_count !== 16'd0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: full=%b count=%0d err=%b, required 0", bank_full, frame_count, err);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        start = 1;
        fill_frame(1200, 1, 0);
        tests++;
        if (bank_full !== 2'b01) begin
            fails++;
            $display("FAIL single_full: bank_full=%b, required 01", bank_full);
        end
        drain_frame(0);
        tests++;
        if (frame_count !== 16'd1 || err !== 1'b0) begin
            fails++;
            $display("FAIL single_end: count=%0d err=%b, required 1/0", frame_count, err);
        end
    endtask

    task automatic test_ping_pong();
        do_reset();
        start = 1;
        out_req = 1;
        fork
            begin
                fill_frame(10, 1, 0);
                fill_frame(20, 1, 1);
                fill_frame(30, 1, 0);
            end
            begin
                drain_frame(1);
                drain_frame(1);
                drain_frame(1);
            end
        join
        out_req = 0;
        tests++;
        if (frame_count !== 16'd3 || err !== 1'b0) begin
            fails++;
            $display("FAIL pingpong_end: count=%0d err=%b, required 3/0", frame_count, err);
        end
    endtask

    task automatic test_both_full();
        int seen;
        int k;
        do_reset();
        start = 1;
        fill_frame(5, 1, 0);
        fill_frame(6, 1, 0);
        in_req = 1;
        seen = 0;
        repeat (5) begin tick(); if (in_grant !== 1'b0) seen++; end
        out_req = 1;
        k = 0;
        while (!out_grant && k < 50) begin tick(); k++; if (in_grant !== 1'b0) seen++; end
        out_req = 0;
        repeat (2) begin tick(); if (in_grant !== 1'b0) seen++; end
        tests++;
        if (seen != 0 || bank_full !== 2'b10) begin
            fails++;
            $display("FAIL bothfull_block: in_grant high %0d cycles full=%b, required 0/10", seen, bank_full);
        end
        out_done = 1;
        tick();
        out_done = 0;
        tests++;
        if (in_grant !== 1'b0) begin
            fails++;
            $display("FAIL bothfull_edge1: in_grant=%b, required 0", in_grant);
        end
        tick();
        in_req = 0;
        tests++;
        if (in_grant !== 1'b1 || in_bank !== 1'b0) begin
            fails++;
            $display("FAIL bothfull_edge2: in_grant=%b in_bank=%b, required 1/0", in_grant, in_bank);
        end
    endtask

    task automatic test_coincident();
        int k;
        do_reset();
        start = 1;
        fill_frame(100, 1, 0);
        out_req = 1;
        k = 0;
        while (!out_grant && k < 50) begin tick(); k++; end
        out_req = 0;
        in_req = 1;
        k = 0;
        while (!in_grant && k < 50) begin tick(); k++; end
        in_req = 0;
        cdf_valid = 1; cdf_min = 20'd200;
        tick();
        cdf_valid = 0;
        in_done = 1; out_done = 1;
        tick();
        in_done = 0; out_done = 0;
        tests++;
        if (bank_full !== 2'b10 || in_grant !== 1'b0 || out_grant !== 1'b0 ||
            err !== 1'b0 || out_bank !== 1'b0 || in_bank !== 1'b1) begin
            fails++;
            $display("FAIL coincident: full=%b ig=%b og=%b err=%b ob=%b ib=%b, required 10/0/0/0/0/1",
                     bank_full, in_grant, out_grant, err, out_bank, in_bank);
        end
    endtask

    task automatic test_errors();
        do_reset();
        start = 1;
        fill_frame(400000, 1, 0);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL over_pre: err=%b, required 0", err);
        end
        drain_frame(0);
        repeat (4) tick();
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL over_err: err=%b, required 1 (sticky)", err);
        end
        do_reset();
        start = 1;
        fill_frame(0, 0, 0);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL nocdf_err: err=%b, required 1", err);
        end
        drain_frame(0);
        do_reset();
        out_done = 1; tick(); out_done = 0;
        repeat (3) tick();
        tests++;
        if (err !== 1'b1 || frame_count !== 16'd0) begin
            fails++;
            $display("FAIL stray_done: err=%b count=%0d, required 1/0", err, frame_count);
        end
        do_reset();
        cdf_valid = 1; tick(); cdf_valid = 0;
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL stray_cdf: err=%b, required 1", err);
        end
    endtask

    task automatic test_start_gate();
        do_reset();
        in_req = 1;
        repeat (4) tick();
        tests++;
        if (in_grant !== 1'b0) begin
            fails++;
            $display("FAIL gate_in: in_grant=%b, required 0", in_grant);
        end
        start = 1;
        tick();
        in_req = 0;
        start = 0;
        cdf_valid = 1; cdf_min = 20'd500; tick(); cdf_valid = 0;
        in_done = 1; tick(); in_done = 0;
        tests++;
        if (in_grant !== 1'b0 || bank_full !== 2'b01 || err !== 1'b0) begin
            fails++;
            $display("FAIL gate_finish: ig=%b full=%b err=%b, required 0/01/0", in_grant, bank_full, err);
        end
        out_req = 1;
        repeat (4) tick();
        tests++;
        if (out_grant !== 1'b0) begin
            fails++;
            $display("FAIL gate_out: out_grant=%b, required 0", out_grant);
        end
        start = 1;
        tick();
        out_req = 0;
        tests++;
        if (out_grant !== 1'b1 || cdf_min_out !== 20'd500 || divisor !== 20'd306700) begin
            fails++;
            $display("FAIL gate_release: og=%b cdf=%0d div=%0d, required 1/500/306700", out_grant, cdf_min_out, divisor);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        start = 1;
        in_req = 1; tick(); in_req = 0;
        cdf_valid = 1; cdf_min = 20'd77; tick(); cdf_valid = 0;
        reset_n = 0;
        #2;
        tests++;
        if ({in_grant, in_bank, out_grant, out_bank, cdf_min_out, divisor, bank_full, frame_count, err} !== '0) begin
            fails++;
            $display("FAIL midfill_reset: ig=%b ib=%b full=%b err=%b, required all 0", in_grant, in_bank, bank_full, err);
        end
        tick();
        reset_n = 1;
        q_cdf.delete(); exp_fill = 0; exp_drain = 0; exp_frames = 0;
        tick();
        fill_frame(50, 1, 0);
        drain_frame(0);
        fill_frame(60, 1, 0);
        fill_frame(70, 1, 0);
        out_req = 1; tick(); tick(); out_req = 0;
        reset_n = 0;
        #2;
        tests++;
        if ({in_grant, in_bank, out_grant, out_bank, cdf_min_out, divisor, bank_full, frame_count, err} !== '0) begin
            fails++;
            $display("FAIL middrain_reset: og=%b cdf=%0d div=%0d full=%b count=%0d, required all 0",
                     out_grant, cdf_min_out, divisor, bank_full, frame_count);
        end
        tick();
        reset_n = 1;
        q_cdf.delete(); exp_fill = 0; exp_drain = 0; exp_frames = 0;
        tick();
        fill_frame(90, 1, 0);
        drain_frame(0);
    endtask

    task automatic test_random();
        int cdf;
        do_reset();
        start = 1;
        for (int op = 0; op < 40; op++) begin
            if (q_cdf.size() == 0 || (q_cdf.size() == 1 && $urandom_range(0, 1) == 0)) begin
                cdf = ($urandom_range(0, 7) == 0) ? PIXELS : int'($urandom_range(0, PIXELS));
                fill_frame(cdf, 1, ($urandom_range(0, 2) == 0));
            end else begin
                drain_frame(0);
            end
        end
        while (q_cdf.size() > 0) drain_frame(0);
        tests++;
        if (err !== 1'b0 || bank_full !== 2'b00) begin
            fails++;
            $display("FAIL random_end: err=%b full=%b, required 0/00", err, bank_full);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_ping_pong();
        test_both_full();
        test_coincident();
        test_errors();
        test_start_gate();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
